// File: rtl/disp_pkg.sv
// disp_pkg: shared types and sizes for the multiplexed 7-segment display path.
//   state_e : scan sequencer state (BLANK = dark gap before a digit, SHOW = digit lit)
//   NDIG    : number of digits scanned
//   BCD_W   : width of one digit value
//   SEL_W   : width of the digit-select decoder address
//   PTR_W   : width of the digit pointer / shadow write address
package disp_pkg;
  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_e;

  localparam int NDIG  = 4;
  localparam int BCD_W = 4;
  localparam int SEL_W = 3;
  localparam int PTR_W = $clog2(NDIG);
endpackage

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: write/commit handshake into the display shadow register.
//   wr_en    : write strobe (master -> slave)
//   wr_addr  : shadow digit index, 0 = rightmost digit (master -> slave)
//   wr_data  : BCD value to store (master -> slave)
//   commit   : request shadow-to-active copy at the next frame boundary (master -> slave)
//   wr_ready : writes and commit are accepted while high (slave -> master)
interface disp_scan_ctrl_if;
  import disp_pkg::*;

  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [BCD_W-1:0] wr_data;
  logic             commit;
  logic             wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, output commit, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, input commit, output wr_ready);
endinterface

// File: rtl/disp_scan_ctrl_scan_timer.sv
// scan_timer: free-running up-counter with a terminal value and a synchronous clear.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : reload the counter to 0 on the next edge
//   term       : terminal count; done is high while the counter equals it
//   done       : terminal-count indication (one cycle when clr is tied back to it)
module scan_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == term);
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit multiplexed 7-segment scan sequencer.
//   Clock      : system clock
//   Aclr       : asynchronous reset, active-low
//   wr_if      : shadow write / commit handshake (slave side)
//   lz_en      : leading-zero suppression enable
//   A          : digit-select address to the 3-to-8 decoder (A[2] = 0)
//   D          : BCD data to the 7-segment decoder
//   BI         : blanking input to the 7-segment decoder, active-low
//   frame_done : one-cycle pulse when the digit-3 dwell ends
// Each digit gets BLANK_CYC dark cycles (select/data change here) followed by
// DIV lit cycles. Committed shadow values become active at the frame boundary.
module disp_scan_ctrl import disp_pkg::*; #(
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 8,
  parameter int CNT_W     = 16
) (
  input  logic              Clock,
  input  logic              Aclr,
  disp_scan_ctrl_if.slave   wr_if,
  input  logic              lz_en,
  output logic [SEL_W-1:0]  A,
  output logic [BCD_W-1:0]  D,
  output logic              BI,
  output logic              frame_done
);
  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_nxt;
  logic [BCD_W-1:0] shadow_q [NDIG];
  logic [BCD_W-1:0] shadow_d [NDIG];
  logic [BCD_W-1:0] active_q [NDIG];
  logic [BCD_W-1:0] active_d [NDIG];
  logic             commit_pend_q, commit_pend_d;
  logic             wr_ready_q, wr_ready_d;
  logic [SEL_W-1:0] a_q, a_d;
  logic [BCD_W-1:0] d_q, d_d;
  logic             bi_q, bi_d;
  logic             frame_done_q, frame_done_d;

  logic             tmr_done;
  logic [CNT_W-1:0] tmr_term;
  logic             wr_acc, commit_acc, frame_edge, copy_now, suppress;
  logic [NDIG:0]    zero_from;

  // zero_from[k] is high when active digits k..NDIG-1 are all zero.
  assign zero_from[NDIG] = 1'b1;
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_zero
    assign zero_from[gi] = (active_q[gi] == '0) & zero_from[gi+1];
  end

  // One timer serves both states; it is reloaded by its own done pulse.
  assign tmr_term = (state_q == BLANK) ? CNT_W'(BLANK_CYC - 1) : CNT_W'(DIV - 1);

  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (Clock),
    .rst_n (Aclr),
    .clr   (tmr_done),
    .term  (tmr_term),
    .done  (tmr_done)
  );

  always_comb begin
    ptr_nxt       = ptr_q + PTR_W'(1);
    frame_edge    = (state_q == SHOW) && tmr_done && (ptr_q == PTR_W'(NDIG - 1));
    copy_now      = frame_edge && commit_pend_q;
    wr_acc        = wr_if.wr_en  & wr_ready_q;
    commit_acc    = wr_if.commit & wr_ready_q;
    suppress      = lz_en && (ptr_q != '0) && zero_from[ptr_q];

    state_d       = state_q;
    ptr_d         = ptr_q;
    a_d           = a_q;
    d_d           = d_q;
    bi_d          = bi_q;
    frame_done_d  = frame_edge;
    shadow_d      = shadow_q;
    active_d      = active_q;
    commit_pend_d = commit_pend_q;
    wr_ready_d    = wr_ready_q;

    if (wr_acc) shadow_d[wr_if.wr_addr] = wr_if.wr_data;

    // A commit accepted on the boundary edge itself has commit_pend_q = 0,
    // so it only arms the copy for the following boundary.
    if (copy_now) begin
      active_d      = shadow_q;
      commit_pend_d = 1'b0;
      wr_ready_d    = 1'b1;
    end else if (commit_acc) begin
      commit_pend_d = 1'b1;
      wr_ready_d    = 1'b0;
    end

    case (state_q)
      BLANK: begin
        if (tmr_done) begin
          state_d = SHOW;
          bi_d    = ~suppress;
        end
      end
      SHOW: begin
        if (tmr_done) begin
          state_d = BLANK;
          ptr_d   = ptr_nxt;
          a_d     = SEL_W'(ptr_nxt);
          // On a copying boundary the new digit 0 comes straight from shadow.
          d_d     = copy_now ? shadow_q[ptr_nxt] : active_q[ptr_nxt];
          bi_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      state_q       <= BLANK;
      ptr_q         <= '0;
      a_q           <= '0;
      d_q           <= '0;
      bi_q          <= 1'b0;
      frame_done_q  <= 1'b0;
      commit_pend_q <= 1'b0;
      wr_ready_q    <= 1'b1;
      for (int i = 0; i < NDIG; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      a_q           <= a_d;
      d_q           <= d_d;
      bi_q          <= bi_d;
      frame_done_q  <= frame_done_d;
      commit_pend_q <= commit_pend_d;
      wr_ready_q    <= wr_ready_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign A              = a_q;
  assign D              = d_q;
  assign BI             = bi_q;
  assign frame_done     = frame_done_q;
  assign wr_if.wr_ready = wr_ready_q;
endmodule
